ccff_chain_loader: RTL

//  Bitstream source for the configuration-chain (ccff) protocol. Accepts bitstream words over a

---
 rtl/ccff_chain_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// Configuration-chain bitstream loader: serializes valid/ready words MSB-first onto ccff_head.
// Define CCFF_READBACK_EN to add a parity-checked recirculating VERIFY pass after LOAD.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 4,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  bit_cnt
);

    localparam logic [CNT_W-1:0] CL = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]  buf_cnt_q, buf_cnt_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    logic              sh_load;
    logic              accept;
    logic [CNT_W-1:0]  committed;
    logic [CNT_W-1:0]  remain;
    logic [CNT_W-1:0]  take;

    assign sh_load   = (state_q == S_LOAD) && (buf_cnt_q != '0);
    assign committed = bit_cnt_q + buf_cnt_q;
    assign remain    = CL - committed;
    // A word may only claim the bits the chain still needs; the excess low bits are dropped.
    assign take      = (32'(remain) > WORD_W) ? CNT_W'(WORD_W) : remain;
    assign bs_ready  = (state_q == S_LOAD) &&
                       ((buf_cnt_q == '0) || ((buf_cnt_q == CNT_W'(1)) && sh_load)) &&
                       (committed < CL);
    assign accept    = bs_valid && bs_ready;

    assign busy    = (state_q == S_LOAD) || (state_q == S_VERIFY);
    assign done    = (state_q == S_DONE);
    assign bit_cnt = bit_cnt_q;

`ifdef CCFF_READBACK_EN
    logic             err_q, err_d;
    logic             load_par_q, load_par_d;
    logic             rb_par_q, rb_par_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;

    assign ccff_shift_en = sh_load || (state_q == S_VERIFY);
    // During VERIFY the chain output is fed straight back so the image survives the pass.
    assign ccff_head     = (state_q == S_VERIFY) ? ccff_tail :
                           (sh_load ? buf_q[WORD_W-1] : 1'b0);
    assign err           = err_q;
`else
    logic unused_tail;

    assign unused_tail   = ccff_tail;
    assign ccff_shift_en = sh_load;
    assign ccff_head     = sh_load ? buf_q[WORD_W-1] : 1'b0;
    assign err           = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        buf_cnt_d = buf_cnt_q;
        bit_cnt_d = bit_cnt_q;
`ifdef CCFF_READBACK_EN
        err_d      = err_q;
        load_par_d = load_par_q;
        rb_par_d   = rb_par_q;
        vcnt_d     = vcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    buf_d     = '0;
                    buf_cnt_d = '0;
                    bit_cnt_d = '0;
`ifdef CCFF_READBACK_EN
                    err_d      = 1'b0;
                    load_par_d = 1'b0;
                    rb_par_d   = 1'b0;
                    vcnt_d     = '0;
`endif
                end
            end
            S_LOAD: begin
                if (sh_load) begin
                    buf_d     = buf_q << 1;
                    buf_cnt_d = buf_cnt_q - CNT_W'(1);
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef CCFF_READBACK_EN
                    load_par_d = load_par_q ^ buf_q[WORD_W-1];
`endif
                end
                // A new word overwrites the buffer in the same edge its last bit leaves.
                if (accept) begin
                    buf_d     = bs_data;
                    buf_cnt_d = take;
                end
                if (bit_cnt_q == CL) begin
`ifdef CCFF_READBACK_EN
                    state_d = S_VERIFY;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_VERIFY: begin
`ifdef CCFF_READBACK_EN
                rb_par_d = rb_par_q ^ ccff_tail;
                vcnt_d   = vcnt_q + CNT_W'(1);
                if (vcnt_q == CL - CNT_W'(1)) begin
                    state_d = S_DONE;
                    err_d   = err_q | (rb_par_d != load_par_q);
                end
`else
                state_d = S_DONE;
`endif
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            buf_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            buf_cnt_q <= buf_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

`ifdef CCFF_READBACK_EN
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            err_q      <= 1'b0;
            load_par_q <= 1'b0;
            rb_par_q   <= 1'b0;
            vcnt_q     <= '0;
        end else begin
            err_q      <= err_d;
            load_par_q <= load_par_d;
            rb_par_q   <= rb_par_d;
            vcnt_q     <= vcnt_d;
        end
    end
`endif

endmodule
